mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one downstream memory port between two requesters: vproc core (port 0) and programming/debug SPI loader (port 1).
//  Sits inside mmu between vproc_top mem interface, SPI loader and the SRAM/peripheral decode.
//  One transaction in flight; round-robin when both request; core masked while in programming mode.
// PARAMETERS
//  ADDR_W          32   address width, all ports
//  DATA_W          32   data width; byte-enable width DATA_W/8
//  TIMEOUT_CYCLES  255  cycles ISSUE+WAIT may last before forced error (MEM_ARB_TIMEOUT_EN only)
// PORTS
//  clk              in   1         clock
//  rst              in   1         synchronous reset, active-high
//  prog_mode_i      in   1         1 = core requests masked (programming mode)
//  req_i[r]         in   2         request per port r; held with fields stable until rvalid_o[r]
//  addr_i[r]        in   2xADDR_W  request address
//  we_i[r]          in   2         1 = write
//  be_i[r]          in   2xDATA_W/8 byte enables
//  wdata_i[r]       in   2xDATA_W  write data
//  rvalid_o[r]      out  2         one-cycle response pulse to port r
//  err_o            out  1         error, valid with rvalid_o
//  rdata_o          out  DATA_W    read data, valid with rvalid_o
//  mem_req_o        out  1         downstream request
//  mem_gnt_i        in   1         downstream accept; transfer on mem_req_o && mem_gnt_i
//  mem_addr_o/we_o/be_o/wdata_o out ADDR_W/1/DATA_W/8/DATA_W  registered request fields
//  mem_rvalid_i     in   1         downstream response, >=1 cycle after gnt
//  mem_err_i        in   1         downstream error, with mem_rvalid_i
//  mem_rdata_i      in   DATA_W    downstream read data
//  busy_o           out  1         FSM not IDLE
//  owner_o          out  1         port owning current/last transaction
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, last_served=1 (core wins first tie).
//  Reset mid-transaction: in-flight response dropped, no rvalid_o.
//  Eligible: e0 = req_i[0] & ~prog_mode_i; e1 = req_i[1].
//  Grant: only one eligible -> it; both -> port != last_served.
//  FSM:
//   IDLE  -> ISSUE on any eligible. Capture winner's fields into mem_*_o; set owner_o.
//            mem_req_o=1 in cycle after req_i seen.
//   ISSUE -> WAIT on mem_gnt_i. mem_req_o and fields stable until gnt; mem_req_o=0 cycle after gnt.
//   WAIT  -> RESP on mem_rvalid_i. Register mem_err_i/mem_rdata_i.
//   RESP  -> IDLE. rvalid_o[owner]=1 one cycle; last_served<=owner.
//  Latency, zero-wait downstream (gnt in first ISSUE cycle, rvalid next cycle): req_i to rvalid_o = 4 cycles.
//  Back-to-back: new grant evaluated in IDLE cycle after RESP.
//  Requester deasserts req_i after rvalid_o, so no re-grant of a served request.
//  prog_mode_i change: in-flight transaction completes to its owner; masking applies at next IDLE decision.
//  mem_rvalid_i outside WAIT: ignored. mem_gnt_i outside ISSUE: ignored.
//  rdata_o/err_o hold last response until next RESP; rvalid_o never high on both ports.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - Counter starts at ISSUE entry, counts through WAIT.
//   - Reaching TIMEOUT_CYCLES -> RESP with err_o=1, rdata_o=0.
//   - Timeout in ISSUE: mem_req_o drops.
//   - Timeout in WAIT: RESP, then DRAIN state; stays until mem_rvalid_i, response discarded, then IDLE.
//     No new grant while in DRAIN.
//  MEM_ARB_TIMEOUT_EN undefined: no counter, no DRAIN state; ISSUE/WAIT wait indefinitely.
// TESTING
//  1. Core read 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF
//     -> rvalid_o[0] 4 cycles after req, rdata_o=0xDEADBEEF, err_o=0.
//  2. Both ports request continuously 6 transactions -> grants alternate 0,1,0,1,0,1; never both rvalid_o.
//  3. prog_mode_i=1, both request -> only port 1 served; core held until prog_mode_i=0, then served.
//  4. gnt delayed 3 cycles, mem_rvalid_i with mem_err_i=1 -> mem_addr_o stable while waiting; err_o=1 with rvalid_o.
//  5. rst asserted in WAIT -> all outputs 0 next cycle; later mem_rvalid_i ignored; no rvalid_o.
//  6. (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) no mem_rvalid_i after gnt -> err_o=1, rdata_o=0.
//     Late mem_rvalid_i is absorbed in DRAIN; next request granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (core = port 0, SPI loader = port 1) in front of one memory port.
// Optional watchdog with DRAIN state for late responses: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_mode_i,
  input  logic [1:0]                 req_i,
  input  logic [1:0][ADDR_W-1:0]     addr_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][DATA_W/8-1:0]   be_i,
  input  logic [1:0][DATA_W-1:0]     wdata_i,
  output logic [1:0]                 rvalid_o,
  output logic                       err_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       mem_we_o,
  output logic [DATA_W/8-1:0]        mem_be_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  output logic                       busy_o,
  output logic                       owner_o,
  output logic [2:0]                 dbg_state_o
);

  // Handshakes: a requester holds req_i and its fields stable until its one-cycle rvalid_o pulse;
  // downstream, a request transfers on mem_req_o && mem_gnt_i, and the response is the first
  // mem_rvalid_i seen in WAIT (mem_gnt_i outside ISSUE and mem_rvalid_i outside WAIT are ignored).
`ifdef MEM_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3, S_DRAIN = 3'd4
  } state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_drain;
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3
  } state_t;
`endif

  state_t r_state;
  logic   r_last;
  logic   w_e0, w_e1, w_any, w_win;

  assign w_e0  = req_i[0] & ~prog_mode_i;
  assign w_e1  = req_i[1];
  assign w_any = w_e0 | w_e1;
  // On a tie the port that was not served last wins; otherwise the only eligible port wins.
  assign w_win = (w_e0 & w_e1) ? ~r_last : w_e1;

  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      rvalid_o    <= '0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      owner_o     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_drain     <= 1'b0;
`endif
    end else begin
      rvalid_o <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_ISSUE;
            owner_o     <= w_win;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= addr_i[w_win];
            mem_we_o    <= we_i[w_win];
            mem_be_o    <= be_i[w_win];
            mem_wdata_o <= wdata_i[w_win];
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_drain     <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            r_state   <= S_WAIT;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout) begin
            mem_req_o <= 1'b0;
            r_state   <= S_RESP;
            err_o     <= 1'b1;
            rdata_o   <= '0;
            r_drain   <= mem_gnt_i;
          end
`endif
        end
        S_WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout && !mem_rvalid_i) begin
            r_state <= S_RESP;
            err_o   <= 1'b1;
            rdata_o <= '0;
            r_drain <= 1'b1;
          end
`endif
          if (mem_rvalid_i) begin
            r_state <= S_RESP;
            err_o   <= mem_err_i;
            rdata_o <= mem_rdata_i;
          end
        end
        S_RESP: begin
          rvalid_o[owner_o] <= 1'b1;
          r_last            <= owner_o;
          r_state           <= S_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          // A late response landing in this very cycle already settles the abandoned transfer.
          if (r_drain && !mem_rvalid_i) r_state <= S_DRAIN;
`endif
        end
`ifdef MEM_ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (mem_rvalid_i) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions, hand sequences for reset/back-to-back/
// timeout, and a random run checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int QW = DW + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  prog_mode_i;
  logic [1:0]            req_i;
  logic [1:0][AW-1:0]    addr_i;
  logic [1:0]            we_i;
  logic [1:0][BW-1:0]    be_i;
  logic [1:0][DW-1:0]    wdata_i;
  logic [1:0]            rvalid_o;
  logic                  err_o;
  logic [DW-1:0]         rdata_o;
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [AW-1:0]         mem_addr_o;
  logic                  mem_we_o;
  logic [BW-1:0]         mem_be_o;
  logic [DW-1:0]         mem_wdata_o;
  logic                  mem_rvalid_i;
  logic                  mem_err_i;
  logic [DW-1:0]         mem_rdata_i;
  logic                  busy_o;
  logic                  owner_o;
  logic [2:0]            dbg_state_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) u_dut (
`else
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
`endif
    .clk(clk), .rst(rst), .prog_mode_i(prog_mode_i),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .owner_o(owner_o), .dbg_state_o(dbg_state_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [QW-1:0] exp_q[$];     // {port, err, rdata} in grant order
  int            served_q[$];
  logic          m_last;
  logic          m_owner;
  int            gd_cnt, rv_cnt;
  logic [DW-1:0] mem_data_nx;
  logic          mem_err_nx;
  logic          prev_mem_req, prev_prog;
  logic [1:0]    prev_req;
  int            idle_cnt[2];

  typedef struct {
    logic        prog;
    logic [1:0]  req;
    int          gd;
    int          rd;
    logic        err;
    logic [31:0] rdata;
    logic        exp_owner;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; prog_mode_i = 1'b0; req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    repeat (3) step();
    rst = 1'b0;
    m_last = 1'b1; m_owner = 1'b0;
    exp_q.delete(); served_q.delete();
    gd_cnt = -1; rv_cnt = 0;
    idle_cnt[0] = 0; idle_cnt[1] = 0;
  endtask

  // One complete transaction with explicit gnt delay (gd) and rvalid delay after gnt (rd).
  task automatic do_txn(input int i, input vec_t v);
    logic [AW-1:0] held;
    logic          p;
    p = v.exp_owner;
    prog_mode_i = v.prog;
    addr_i[0] = 32'h100 + i * 16; we_i[0] = 1'b0; be_i[0] = 4'hF; wdata_i[0] = '0;
    addr_i[1] = 32'h8000 + i * 4; we_i[1] = 1'b1; be_i[1] = 4'h3; wdata_i[1] = 32'hC0DE_0000 + i;
    req_i = v.req;
    step();
    chk("txn_mem_req", mem_req_o, 1);
    chk("txn_owner", owner_o, p);
    chk("txn_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
        {addr_i[p], we_i[p], be_i[p], wdata_i[p]});
    held = mem_addr_o;
    for (int k = 0; k < v.gd; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_0000 + k;
      step();
      mem_rvalid_i = 1'b0;
      chk("issue_hold", {mem_req_o, mem_addr_o}, {1'b1, held});
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("req_drop_after_gnt", mem_req_o, 0);
    for (int k = 1; k < v.rd; k++) step();
    mem_rvalid_i = 1'b1; mem_err_i = v.err; mem_rdata_i = v.rdata;
    step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    chk("resp_cycle_rvalid", rvalid_o, 0);
    step();
    chk("rvalid", rvalid_o, p ? 2'b10 : 2'b01);
    chk("rdata", rdata_o, v.rdata);
    chk("err", err_o, v.err);
    req_i = '0;
    step();
    chk("idle_after", {rvalid_o, busy_o}, 0);
    chk("rdata_hold", rdata_o, v.rdata);
  endtask

  // Downstream memory responder; drives mem_* inputs for the coming cycle.
  task automatic mem_tick(input int max_gd, input int max_rd);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1; mem_err_i = mem_err_nx; mem_rdata_i = mem_data_nx;
      end
    end
    if (mem_req_o) begin
      if (gd_cnt < 0) gd_cnt = $urandom_range(max_gd, 0);
      if (gd_cnt == 0) begin
        mem_gnt_i   = 1'b1;
        gd_cnt      = -1;
        rv_cnt      = $urandom_range(max_rd, 1);
        mem_data_nx = $urandom;
        mem_err_nx  = ($urandom_range(7, 0) == 0);
        exp_q.push_back({m_owner, mem_err_nx, mem_data_nx});
      end else begin
        gd_cnt--;
      end
    end
  endtask

  // mode 0: random requesters, 1: both ports always requesting, 2: finish outstanding only.
  task automatic run_cycles(input int n, input int mode, input int max_gd, input int max_rd);
    logic [QW-1:0] e;
    logic          e0, e1, done;
    int            starve;
    starve = 0;
    done = 1'b0;
    prev_req = req_i; prev_prog = prog_mode_i; prev_mem_req = mem_req_o;
    for (int c = 0; c < n && !done; c++) begin
      step();
      if (rvalid_o != 2'b00) begin
        starve = 0;
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", rvalid_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_rvalid_port", rvalid_o, e[QW-1] ? 2'b10 : 2'b01);
          chk("rnd_rdata", rdata_o, e[DW-1:0]);
          chk("rnd_err", err_o, e[DW]);
          m_last = e[QW-1];
          served_q.push_back(int'(e[QW-1]));
          if (mode != 1) begin
            req_i[e[QW-1]]    = 1'b0;
            idle_cnt[e[QW-1]] = $urandom_range(2, 0);
          end
        end
      end
      if (mem_req_o && !prev_mem_req) begin
        e0 = prev_req[0] & ~prev_prog;
        e1 = prev_req[1];
        chk("grant_eligible", e0 | e1, 1);
        m_owner = (e0 && e1) ? ~m_last : e1;
        chk("rnd_owner", owner_o, m_owner);
        chk("rnd_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
            {addr_i[m_owner], we_i[m_owner], be_i[m_owner], wdata_i[m_owner]});
      end
      mem_tick(max_gd, max_rd);
      for (int p = 0; p < 2; p++) begin
        if (!req_i[p]) begin
          if (idle_cnt[p] > 0) idle_cnt[p]--;
          else if (mode == 0 && $urandom_range(2, 0) == 0) begin
            req_i[p]   = 1'b1;
            addr_i[p]  = $urandom;
            we_i[p]    = 1'($urandom);
            be_i[p]    = BW'($urandom);
            wdata_i[p] = $urandom;
          end
        end
      end
      if (mode == 0 && $urandom_range(15, 0) == 0) prog_mode_i = ~prog_mode_i;
      if (req_i[1] || (req_i[0] && !prog_mode_i)) starve++;
      if (starve > 60) begin
        chk("progress_cycles", starve, 0);
        done = 1'b1;
      end
      if (mode == 2 && req_i == 2'b00 && !busy_o && exp_q.size() == 0 && rv_cnt == 0) done = 1'b1;
      prev_req = req_i; prev_prog = prog_mode_i; prev_mem_req = mem_req_o;
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];
  int   lat;
  logic found;

  initial begin
    // prog, req, gnt delay, rvalid delay, err, rdata, expected owner (last_served starts at 1)
    vecs[0] = '{1'b0, 2'b01, 0, 1, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 2'b11, 1, 2, 1'b0, 32'h11111111, 1'b1};
    vecs[2] = '{1'b0, 2'b11, 0, 1, 1'b0, 32'h22222222, 1'b0};
    vecs[3] = '{1'b1, 2'b11, 2, 1, 1'b0, 32'h33333333, 1'b1};
    vecs[4] = '{1'b1, 2'b11, 0, 3, 1'b0, 32'h44444444, 1'b1};
    vecs[5] = '{1'b0, 2'b10, 0, 1, 1'b0, 32'h55555555, 1'b1};
    vecs[6] = '{1'b0, 2'b11, 3, 1, 1'b1, 32'h66666666, 1'b0};
    vecs[7] = '{1'b0, 2'b10, 1, 1, 1'b0, 32'h77777777, 1'b1};

    do_reset();
    chk("reset_outputs", {rvalid_o, err_o, rdata_o, mem_req_o, mem_addr_o, busy_o, owner_o}, 0);
    chk("reset_state", dbg_state_o, 0);

    for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

    // Reset while waiting for the response of a port-1 write.
    req_i = 2'b10; addr_i[1] = 32'hABCD_0000; we_i[1] = 1'b1; be_i[1] = 4'hF; wdata_i[1] = 32'h1;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("pre_rst_busy", {busy_o, owner_o}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_i = '0;
    chk("rst_mid_outputs", {rvalid_o, err_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o,
                            mem_be_o, mem_wdata_o, busy_o, owner_o}, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5151_5151;
    step();
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_late_rvalid_ignored", {rvalid_o, busy_o, rdata_o}, 0);
    end

    // Both ports requesting continuously: grants alternate starting with the core.
    do_reset();
    addr_i[0] = 32'h0000_1000; addr_i[1] = 32'h0000_2000; be_i = '1;
    req_i = 2'b11;
    run_cycles(30, 1, 0, 1);
    run_cycles(100, 2, 0, 1);
    chk("b2b_count", served_q.size() >= 6, 1);
    if (served_q.size() >= 6)
      for (int k = 0; k < 6; k++) chk("b2b_order", served_q[k], k % 2);

    // Random traffic against the round-robin model.
    do_reset();
    run_cycles(1500, 0, 3, 3);
    prog_mode_i = 1'b0;
    run_cycles(200, 2, 3, 3);
    chk("drain_empty", {exp_q.size() == 0, req_i, busy_o}, 4'b1000);

`ifdef MEM_ARB_TIMEOUT_EN
    // Granted read never answered: timeout error, DRAIN absorbs the late response.
    do_reset();
    req_i = 2'b01; addr_i[0] = 32'h200; we_i[0] = 1'b0; be_i[0] = 4'hF;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    lat = 2; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      lat++;
      if (rvalid_o != 2'b00) found = 1'b1;
    end
    chk("to_seen", found, 1);
    chk("to_rvalid", rvalid_o, 2'b01);
    chk("to_err_rdata", {err_o, rdata_o}, {1'b1, 32'h0});
    req_i = 2'b10; addr_i[1] = 32'h300; we_i[1] = 1'b0; be_i[1] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drain_no_grant", {mem_req_o, busy_o}, 2'b01);
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_FEED;
    step();
    mem_rvalid_i = 1'b0;
    chk("drain_absorbed", rvalid_o, 0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      step();
      if (mem_req_o) found = 1'b1;
    end
    chk("post_drain_grant", {found, owner_o, mem_addr_o}, {1'b1, 1'b1, 32'h300});
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b0; mem_rdata_i = 32'h0000_600D;
    step();
    mem_rvalid_i = 1'b0;
    step();
    chk("post_drain_resp", {rvalid_o, err_o, rdata_o}, {2'b10, 1'b0, 32'h0000_600D});
    req_i = '0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
